// File: rtl/m_store_unit_if.sv
// Store-unit connection bundle: M-stage store request/status and the write bus to memory.
interface m_store_unit_if;
  logic [1:0]  M_StoreOp;
  logic        M_Valid;
  logic [31:0] M_Addr;
  logic [31:0] M_WD;
  logic        M_AdES;
  logic        M_Stall;
  logic        M_Busy;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ack;

  modport slave (
    input  M_StoreOp, M_Valid, M_Addr, M_WD, bus_ack,
    output M_AdES, M_Stall, M_Busy, bus_req, bus_addr, bus_wdata, bus_byteen
  );

  modport master (
    output M_StoreOp, M_Valid, M_Addr, M_WD, bus_ack,
    input  M_AdES, M_Stall, M_Busy, bus_req, bus_addr, bus_wdata, bus_byteen
  );
endinterface

// File: rtl/m_store_unit.sv
// M-stage store buffer: packs sw/sh/sb into lane-aligned writes, queues them in a
// small FIFO and drains the head to memory over a req/ack bus with registered outputs.
module m_store_unit #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  m_store_unit_if.slave m
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SW   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_SB   = 2'b11;

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;

  // Returns {byteen, wdata}; narrow stores replicate the low bytes across all lanes.
  function automatic logic [35:0] pack_store(input logic [1:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] wd);
    logic [35:0] r;
    case (op)
      OP_SW:   r = {4'b1111, wd};
      OP_SH:   r = lane[1] ? {4'b1100, wd[15:0], wd[15:0]}
                           : {4'b0011, wd[15:0], wd[15:0]};
      OP_SB:   r = {4'b0001 << lane, {4{wd[7:0]}}};
      default: r = 36'd0;
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [1:0]       occ;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  be_mem   [DEPTH];

  logic        st_req;
  logic        ades;
  logic        enq;
  logic        deq;
  logic [35:0] pk;

  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;

  logic        req_nxt;
  logic [29:0] addr_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  be_nxt;

  logic        req_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  always_comb begin
    occ = ST_PARTIAL;
    if (count == '0)
      occ = ST_EMPTY;
    else if (count == CNT_FULL)
      occ = ST_FULL;
  end

  always_comb begin
    st_req = m.M_Valid & (m.M_StoreOp != OP_NONE);
    ades   = st_req & (((m.M_StoreOp == OP_SW) & (m.M_Addr[1:0] != 2'b00)) |
                       ((m.M_StoreOp == OP_SH) & m.M_Addr[0]));
    enq    = st_req & ~ades & (occ != ST_FULL);
    deq    = (occ != ST_EMPTY) & m.bus_ack;
    pk     = pack_store(m.M_StoreOp, m.M_Addr[1:0], m.M_WD);
  end

  // Next-state of the queue and of the registered head presentation.
  always_comb begin
    remain    = count - CNT_W'(deq);
    count_nxt = remain + CNT_W'(enq);
    head_nxt  = deq ? head + PTR_W'(1) : head;
    tail_nxt  = enq ? tail + PTR_W'(1) : tail;
    req_nxt   = (count_nxt != '0);
    addr_nxt  = '0;
    wdata_nxt = '0;
    be_nxt    = '0;
    if (enq && (remain == '0)) begin
      // The incoming store becomes the head straight away.
      addr_nxt  = m.M_Addr[31:2];
      wdata_nxt = pk[31:0];
      be_nxt    = pk[35:32];
    end else if (req_nxt) begin
      addr_nxt  = addr_mem[head_nxt];
      wdata_nxt = data_mem[head_nxt];
      be_nxt    = be_mem[head_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      count   <= count_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      be_q    <= be_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= m.M_Addr[31:2];
      data_mem[tail] <= pk[31:0];
      be_mem[tail]   <= pk[35:32];
    end
  end

  assign m.M_AdES     = ades;
  assign m.M_Stall    = st_req & ~ades & (occ == ST_FULL);
  assign m.M_Busy     = (occ != ST_EMPTY);
  assign m.bus_req    = req_q;
  assign m.bus_addr   = {addr_q, 2'b00};
  assign m.bus_wdata  = wdata_q;
  assign m.bus_byteen = be_q;

endmodule

// File: tb/tb_m_store_unit.sv
// Directed bench for m_store_unit (DEPTH=2): packing, faults, stall/drain ordering and reset.
module tb_m_store_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  m_store_unit_if sif ();

  m_store_unit #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    sif.M_Valid   = 1'b1;
    sif.M_StoreOp = op;
    sif.M_Addr    = addr;
    sif.M_WD      = wd;
  endtask

  task automatic idle();
    sif.M_Valid   = 1'b0;
    sif.M_StoreOp = 2'b00;
    sif.M_Addr    = 32'h0;
    sif.M_WD      = 32'h0;
  endtask

  initial begin
    reset       = 1'b1;
    sif.bus_ack = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_req",   32'(sif.bus_req), 32'h0);
    chk("rst_addr",  sif.bus_addr, 32'h0);
    chk("rst_wdata", sif.bus_wdata, 32'h0);
    chk("rst_be",    32'(sif.bus_byteen), 32'h0);
    chk("rst_busy",  32'(sif.M_Busy), 32'h0);
    chk("rst_stall", 32'(sif.M_Stall), 32'h0);

    // sb at 0x3003 with ack held high
    sif.bus_ack = 1'b1;
    store(2'b11, 32'h0000_3003, 32'h1234_56AB);
    #1;
    chk("sb_ades", 32'(sif.M_AdES), 32'h0);
    step();
    idle();
    #1;
    chk("sb_req",   32'(sif.bus_req), 32'h1);
    chk("sb_addr",  sif.bus_addr, 32'h0000_3000);
    chk("sb_be",    32'(sif.bus_byteen), 32'h8);
    chk("sb_wdata", sif.bus_wdata, 32'hABAB_ABAB);
    step();
    chk("sb_drain_req",  32'(sif.bus_req), 32'h0);
    chk("sb_drain_busy", 32'(sif.M_Busy), 32'h0);
    chk("sb_drain_addr", sif.bus_addr, 32'h0);

    // sh upper half, then misaligned sh and sw
    sif.bus_ack = 1'b0;
    store(2'b10, 32'h0000_0006, 32'hFFFF_8001);
    step();
    idle();
    #1;
    chk("sh_req",   32'(sif.bus_req), 32'h1);
    chk("sh_addr",  sif.bus_addr, 32'h0000_0004);
    chk("sh_be",    32'(sif.bus_byteen), 32'hC);
    chk("sh_wdata", sif.bus_wdata, 32'h8001_8001);
    sif.bus_ack = 1'b1;
    step();
    sif.bus_ack = 1'b0;
    chk("sh_drain_req", 32'(sif.bus_req), 32'h0);
    store(2'b10, 32'h0000_0005, 32'h0000_1111);
    #1;
    chk("sh_odd_ades",  32'(sif.M_AdES), 32'h1);
    chk("sh_odd_stall", 32'(sif.M_Stall), 32'h0);
    step();
    store(2'b01, 32'h0000_0102, 32'h0000_2222);
    #1;
    chk("sw_mis_ades", 32'(sif.M_AdES), 32'h1);
    step();
    idle();
    #1;
    chk("fault_req",  32'(sif.bus_req), 32'h0);
    chk("fault_busy", 32'(sif.M_Busy), 32'h0);

    // sh lower half at 0x10, sb lane 1 at 0x11: no faults, correct lanes
    store(2'b10, 32'h0000_0010, 32'h0000_BEEF);
    step();
    store(2'b11, 32'h0000_0011, 32'hFFFF_FFCD);
    #1;
    chk("sb1_ades", 32'(sif.M_AdES), 32'h0);
    chk("shl_be",   32'(sif.bus_byteen), 32'h3);
    chk("shl_wdata", sif.bus_wdata, 32'hBEEF_BEEF);
    step();
    idle();
    sif.bus_ack = 1'b1;
    step();
    chk("sb1_be",    32'(sif.bus_byteen), 32'h2);
    chk("sb1_wdata", sif.bus_wdata, 32'hCDCD_CDCD);
    chk("sb1_addr",  sif.bus_addr, 32'h0000_0010);
    step();
    sif.bus_ack = 1'b0;
    chk("sb1_drain", 32'(sif.bus_req), 32'h0);

    // three back-to-back sw into a two-entry buffer
    store(2'b01, 32'h0000_0100, 32'h1111_1111);
    #1;
    chk("bb1_stall", 32'(sif.M_Stall), 32'h0);
    step();
    store(2'b01, 32'h0000_0104, 32'h2222_2222);
    #1;
    chk("bb2_stall", 32'(sif.M_Stall), 32'h0);
    step();
    store(2'b01, 32'h0000_0108, 32'h3333_3333);
    #1;
    chk("bb3_stall", 32'(sif.M_Stall), 32'h1);
    chk("bb_head1",  sif.bus_addr, 32'h0000_0100);
    step();
    chk("bb3_stall_hold", 32'(sif.M_Stall), 32'h1);
    chk("bb_head1_hold",  sif.bus_addr, 32'h0000_0100);
    chk("bb_wd1_hold",    sif.bus_wdata, 32'h1111_1111);
    sif.bus_ack = 1'b1;
    #1;
    chk("bb_stall_w_ack", 32'(sif.M_Stall), 32'h1);
    step();
    sif.bus_ack = 1'b0;
    #1;
    chk("bb_stall_rel", 32'(sif.M_Stall), 32'h0);
    chk("bb_head2",     sif.bus_addr, 32'h0000_0104);
    chk("bb_wd2",       sif.bus_wdata, 32'h2222_2222);
    step();
    idle();
    #1;
    chk("bb_head2_hold", sif.bus_addr, 32'h0000_0104);
    sif.bus_ack = 1'b1;
    step();
    chk("bb_req3",  32'(sif.bus_req), 32'h1);
    chk("bb_head3", sif.bus_addr, 32'h0000_0108);
    chk("bb_wd3",   sif.bus_wdata, 32'h3333_3333);
    step();
    sif.bus_ack = 1'b0;
    chk("bb_empty", 32'(sif.bus_req), 32'h0);

    // count 1: simultaneous enqueue and dequeue
    store(2'b01, 32'h0000_0200, 32'hAAAA_0001);
    step();
    store(2'b01, 32'h0000_0204, 32'hBBBB_0002);
    sif.bus_ack = 1'b1;
    #1;
    chk("sim_stall", 32'(sif.M_Stall), 32'h0);
    chk("sim_head0", sif.bus_addr, 32'h0000_0200);
    step();
    idle();
    sif.bus_ack = 1'b0;
    #1;
    chk("sim_req",   32'(sif.bus_req), 32'h1);
    chk("sim_addr",  sif.bus_addr, 32'h0000_0204);
    chk("sim_wdata", sif.bus_wdata, 32'hBBBB_0002);
    sif.bus_ack = 1'b1;
    step();
    sif.bus_ack = 1'b0;
    chk("sim_count1", 32'(sif.bus_req), 32'h0);

    // ack while idle is ignored
    sif.bus_ack = 1'b1;
    step();
    step();
    sif.bus_ack = 1'b0;
    chk("idle_ack_req",  32'(sif.bus_req), 32'h0);
    chk("idle_ack_busy", 32'(sif.M_Busy), 32'h0);

    // reset while FULL with ack and a pending store
    store(2'b01, 32'h0000_0300, 32'hC0C0_C0C0);
    step();
    store(2'b01, 32'h0000_0304, 32'hC1C1_C1C1);
    step();
    store(2'b01, 32'h0000_0308, 32'hC2C2_C2C2);
    #1;
    chk("full_stall", 32'(sif.M_Stall), 32'h1);
    reset       = 1'b1;
    sif.bus_ack = 1'b1;
    step();
    reset       = 1'b0;
    sif.bus_ack = 1'b0;
    idle();
    #1;
    chk("mrst_req",   32'(sif.bus_req), 32'h0);
    chk("mrst_addr",  sif.bus_addr, 32'h0);
    chk("mrst_wdata", sif.bus_wdata, 32'h0);
    chk("mrst_be",    32'(sif.bus_byteen), 32'h0);
    chk("mrst_busy",  32'(sif.M_Busy), 32'h0);
    sif.bus_ack = 1'b1;
    step();
    step();
    sif.bus_ack = 1'b0;
    chk("mrst_noreplay", 32'(sif.bus_req), 32'h0);

    // reset beats an enqueue into an empty buffer
    store(2'b01, 32'h0000_0400, 32'hDEAD_BEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_enq_req",  32'(sif.bus_req), 32'h0);
    chk("rst_enq_busy", 32'(sif.M_Busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_store_unit.md
M_STORE_UNIT -- requirements
Module: M_STORE_UNIT

Interface
REQ-001 Parameter DEPTH, default 2: number of store-buffer entries; legal values 2 and 4 only.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port reset  input  1: synchronous, active-high reset.
REQ-004 Port M_StoreOp  input  2: store type; 00 none, 01 sw, 10 sh, 11 sb.
REQ-005 Port M_Valid  input  1: M-stage instruction valid (not flushed, not bubble).
REQ-006 Port M_Addr  input  32: byte address of the store.
REQ-007 Port M_WD  input  32: forwarded rt store data.
REQ-008 Port M_AdES  output  1: store address error, combinational.
REQ-009 Port M_Stall  output  1: pipeline stall request, combinational.
REQ-010 Port M_Busy  output  1: buffer non-empty.
REQ-011 Port bus_req  output  1: write request to memory/bridge.
REQ-012 Port bus_addr  output  32: word-aligned write address, bits [1:0] always 00.
REQ-013 Port bus_wdata  output  32: lane-aligned write data.
REQ-014 Port bus_byteen  output  4: byte enables; bit i enables bus_wdata[8i+7:8i].
REQ-015 Port bus_ack  input  1: memory accepted the presented head entry this cycle.

Function
REQ-016 Store request = M_Valid & (M_StoreOp != 00).
REQ-017 M_AdES = store request & ((sw & M_Addr[1:0] != 00) | (sh & M_Addr[0] != 0)); sb never faults.
REQ-018 Packing: sw -> byteen 1111, wdata M_WD.
REQ-019 Packing: sh -> byteen 0011 (Addr[1]=0) or 1100 (Addr[1]=1), wdata {M_WD[15:0], M_WD[15:0]}.
REQ-020 Packing: sb -> byteen = 0001 << Addr[1:0], wdata {4{M_WD[7:0]}}.
REQ-021 Entry stored = {Addr[31:2], 00}, packed wdata, byteen; narrowing truncates M_WD, with no sign or zero extension on write.
REQ-022 Buffer is a FIFO of DEPTH entries with head/tail pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-023 Occupancy states: EMPTY (count 0), PARTIAL (1..DEPTH-1), FULL (count DEPTH).
REQ-024 Enqueue when store request & !M_AdES & !FULL; a faulting store is never enqueued.
REQ-025 M_Stall = store request & !M_AdES & FULL, independent of bus_ack in the same cycle.
REQ-026 bus_req = (count != 0); bus_addr/wdata/byteen present the head entry, registered output.
REQ-027 Latency: a store enqueued into EMPTY at edge N appears with bus_req=1 in the cycle after edge N.
REQ-028 While bus_req & !bus_ack, the head entry and bus outputs hold stable.
REQ-029 bus_req & bus_ack dequeues the head at the edge; the next entry, if any, is presented the following cycle with bus_req staying 1.
REQ-030 bus_ack while bus_req=0 is ignored, with no state change.
REQ-031 Simultaneous enqueue and dequeue in PARTIAL leaves count unchanged; FIFO order is preserved.
REQ-032 Dequeue from FULL with a stalled store pending: count drops at the edge, and the store enqueues on the next cycle (M_Stall deasserts then).
REQ-033 M_Busy = (count != 0); it is used to drain before syscall/eret.
REQ-034 When bus_req=0, bus_addr, bus_wdata and bus_byteen are driven 0.

Reset
REQ-035 On reset: count=0, pointers=0, bus_req=0, bus_addr=0, bus_wdata=0, bus_byteen=0000, M_Busy=0.
REQ-036 Reset mid-transaction discards all entries, including an un-acked head; bus_req is 0 the cycle after the reset edge.
REQ-037 Reset has priority over simultaneous enqueue and bus_ack.

Verification
REQ-038 sb, Addr=0x00003003, WD=0x123456AB, bus_ack held 1 -> next cycle bus_req=1, addr=0x00003000, byteen=1000, wdata=0xABABABAB; then EMPTY.
REQ-039 sh, Addr=0x00000006, WD=0xFFFF8001 -> byteen=1100, wdata=0x80018001; sh at 0x00000005 -> M_AdES=1, nothing enqueued, bus_req stays 0.
REQ-040 DEPTH=2, bus_ack=0, three back-to-back sw -> first two enqueue, third gives M_Stall=1; ack one -> third enqueues the next cycle, and bus order is 1, 2, 3.
REQ-041 PARTIAL with count 1, simultaneous sw enqueue and bus_ack -> count stays 1, and the new entry is presented the next cycle.
REQ-042 FULL, bus_req=1, reset asserted one cycle with bus_ack=1 -> all outputs 0 the next cycle, and no entry is later replayed.
